// File: rtl/ad5761r_spi_slave_if.sv
// ---------------------------------------------------------------------------
// ad5761r_spi_slave_if
// Pin bundle of an AD5761R-style DAC serial port.
//   DAC_SCLK    : serial clock from master, idles high
//   DAC_CS_N    : frame select, active-low
//   DAC_DIN     : serial data into the DAC, MSB first
//   DAC_DOUT    : serial readback data out of the DAC
//   DAC_RESET_N : hardware reset pin, active-low level
//   DAC_LOAD_N  : LDAC pin, falling edge copies input reg to DAC reg
//   DAC_CLEAR_N : clear pin, active-low level
//   DAC_ALERT_N : alert output, active-low
// Modports: master (host/bench side), slave (DAC model side).
// ---------------------------------------------------------------------------
interface ad5761r_spi_slave_if;
  logic DAC_SCLK;
  logic DAC_CS_N;
  logic DAC_DIN;
  logic DAC_DOUT;
  logic DAC_RESET_N;
  logic DAC_LOAD_N;
  logic DAC_CLEAR_N;
  logic DAC_ALERT_N;

  modport master (
    output DAC_SCLK, DAC_CS_N, DAC_DIN, DAC_RESET_N, DAC_LOAD_N, DAC_CLEAR_N,
    input  DAC_DOUT, DAC_ALERT_N
  );

  modport slave (
    input  DAC_SCLK, DAC_CS_N, DAC_DIN, DAC_RESET_N, DAC_LOAD_N, DAC_CLEAR_N,
    output DAC_DOUT, DAC_ALERT_N
  );
endinterface

// File: rtl/ad5761r_spi_slave.sv
// ---------------------------------------------------------------------------
// ad5761r_spi_slave
// Behavioural SPI slave of an AD5761R DAC, running entirely in the clk domain.
// All pins are 2-FF synchronised and edge-detected; SCLK period must be at
// least 8 clk.
//
// Ports:
//   clk        : system clock (50 MHz)
//   rst_n      : asynchronous active-low reset
//   spi        : ad5761r_spi_slave_if.slave pin bundle
//   dac_code   : current DAC register
//   ctrl_reg   : current control register
//   frame_err  : one-clk pulse on a malformed frame (frame check build only)
//
// Build option:
//   AD5761R_SLV_FRAME_CHECK_EN defined   -> only 24-bit frames execute; other
//                                           lengths are dropped and pulse
//                                           frame_err.
//   AD5761R_SLV_FRAME_CHECK_EN undefined -> the last 24 bits shifted always
//                                           execute; frame_err is tied low.
// ---------------------------------------------------------------------------
module ad5761r_spi_slave (
  input  logic                      clk,
  input  logic                      rst_n,
  ad5761r_spi_slave_if.slave        spi,
  output logic [15:0]               dac_code,
  output logic [10:0]               ctrl_reg,
  output logic                      frame_err
);

  localparam int FRAME_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Range select shared by power-up (PV) and clear (CV) fields.
  function automatic logic [15:0] range_code(input logic [1:0] sel);
    if (sel[1])      return 16'hFFFF;
    else if (sel[0]) return 16'h8000;
    else             return 16'h0000;
  endfunction

  // ---- stage p0/p1: pin synchronisers, p2: previous value for edges ----
  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_n_p0, cs_n_p1, cs_n_p2;
  logic din_p0, din_p1;
  logic load_n_p0, load_n_p1, load_n_p2;
  logic clear_n_p0, clear_n_p1;
  logic reset_n_p0, reset_n_p1;

  // Pins idle high, so the synchronisers come out of reset at the idle level
  // to avoid phantom edges or a phantom pin reset right after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0    <= 1'b1; sclk_p1    <= 1'b1; sclk_p2   <= 1'b1;
      cs_n_p0    <= 1'b1; cs_n_p1    <= 1'b1; cs_n_p2   <= 1'b1;
      din_p0     <= 1'b0; din_p1     <= 1'b0;
      load_n_p0  <= 1'b1; load_n_p1  <= 1'b1; load_n_p2 <= 1'b1;
      clear_n_p0 <= 1'b1; clear_n_p1 <= 1'b1;
      reset_n_p0 <= 1'b1; reset_n_p1 <= 1'b1;
    end else begin
      sclk_p0    <= spi.DAC_SCLK;    sclk_p1    <= sclk_p0;    sclk_p2   <= sclk_p1;
      cs_n_p0    <= spi.DAC_CS_N;    cs_n_p1    <= cs_n_p0;    cs_n_p2   <= cs_n_p1;
      din_p0     <= spi.DAC_DIN;     din_p1     <= din_p0;
      load_n_p0  <= spi.DAC_LOAD_N;  load_n_p1  <= load_n_p0;  load_n_p2 <= load_n_p1;
      clear_n_p0 <= spi.DAC_CLEAR_N; clear_n_p1 <= clear_n_p0;
      reset_n_p0 <= spi.DAC_RESET_N; reset_n_p1 <= reset_n_p0;
    end
  end

  logic sclk_fall, sclk_rise, cs_fall, cs_rise, load_fall;
  assign sclk_fall = sclk_p2 & ~sclk_p1;
  assign sclk_rise = ~sclk_p2 & sclk_p1;
  assign cs_fall   = cs_n_p2 & ~cs_n_p1;
  assign cs_rise   = ~cs_n_p2 & cs_n_p1;
  assign load_fall = load_n_p2 & ~load_n_p1;

  // ---- frame shifting and control decode ----
  logic [FRAME_W-1:0] rx_sr;
  logic [FRAME_W-1:0] tx_sr;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] rb_word;
  logic [15:0]        in_q, dac_q;
  logic [10:0]        ctrl_q;
  logic               daisy_q;
  logic               alert_n_q;

  logic frame_start, shift_act, exec_st, frame_ok, exec_go, soft_rst;
  logic [3:0]  cmd;
  logic [15:0] data;

  // Command sits in bits 19:16, directly below a don't-care nibble; this is
  // the same layout the readback word uses.
  assign cmd  = rx_sr[19:16];
  assign data = rx_sr[15:0];

`ifdef AD5761R_SLV_FRAME_CHECK_EN
  assign frame_ok = (bit_cnt == 5'd24);
`else
  assign frame_ok = 1'b1;
`endif

  assign exec_go  = exec_st & frame_ok;
  assign soft_rst = ~reset_n_p1 | (exec_go & (cmd == 4'hF));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= ST_IDLE;
    else if (soft_rst) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  // FSM next state; a CS_N rise seen in IDLE is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    frame_start = 1'b0;
    shift_act   = 1'b0;
    exec_st     = 1'b0;
    case (state)
      ST_IDLE:  frame_start = cs_fall;
      ST_SHIFT: shift_act   = 1'b1;
      ST_EXEC:  exec_st     = 1'b1;
      default:  ;
    endcase
  end

  // Serial shift registers. rx_sr is not cleared per frame so that a short
  // frame still executes on the last 24 bits seen on DIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr   <= '0;
      tx_sr   <= '0;
      bit_cnt <= '0;
    end else if (soft_rst) begin
      rx_sr   <= '0;
      tx_sr   <= '0;
      bit_cnt <= '0;
    end else if (frame_start) begin
      bit_cnt <= '0;
      tx_sr   <= rb_word;
    end else if (shift_act) begin
      if (sclk_fall) begin
        rx_sr <= {rx_sr[FRAME_W-2:0], din_p1};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      // Zero fill: DOUT reads 0 once all 24 readback bits are out.
      if (sclk_rise) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
    end else if (exec_st) begin
      tx_sr <= '0;
    end
  end

  // ---- stage exec: register file update ----
  // Later assignments win: LDAC edge, then the EXEC write, then CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      dac_q     <= '0;
      ctrl_q    <= '0;
      daisy_q   <= 1'b0;
      rb_word   <= '0;
      alert_n_q <= 1'b0;
    end else if (soft_rst) begin
      in_q      <= '0;
      dac_q     <= '0;
      ctrl_q    <= '0;
      daisy_q   <= 1'b0;
      rb_word   <= '0;
      alert_n_q <= 1'b0;
    end else begin
      // A pending readback is single-use: the next frame takes it.
      if (frame_start) rb_word <= '0;
      if (load_fall)   dac_q   <= in_q;
      if (exec_go) begin
        case (cmd)
          4'h1: begin
            in_q <= data;
            if (!load_n_p1) dac_q <= data;
          end
          4'h2: dac_q <= in_q;
          4'h3: begin
            in_q  <= data;
            dac_q <= data;
          end
          4'h4: begin
            ctrl_q    <= data[10:0];
            alert_n_q <= 1'b1;
          end
          4'h7: begin
            in_q  <= range_code(ctrl_q[4:3]);
            dac_q <= range_code(ctrl_q[4:3]);
          end
          4'h9: daisy_q <= data[0];
          4'hA: rb_word <= {4'h0, cmd, in_q};
          4'hB: rb_word <= {4'h0, cmd, dac_q};
          4'hC: rb_word <= {4'h0, cmd, 5'h00, ctrl_q};
          default: ;
        endcase
      end
      if (!clear_n_p1) dac_q <= range_code(ctrl_q[10:9]);
    end
  end

`ifdef AD5761R_SLV_FRAME_CHECK_EN
  logic frame_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        frame_err_q <= 1'b0;
    else if (soft_rst) frame_err_q <= 1'b0;
    else               frame_err_q <= exec_st & ~frame_ok;
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  // Daisy-chain mode, the don't-care nibble and the raw bit count have no
  // observable effect in this model.
  logic unused_bits;
  assign unused_bits = ^{rx_sr[23:20], daisy_q, bit_cnt};

  assign dac_code        = dac_q;
  assign ctrl_reg        = ctrl_q;
  assign spi.DAC_DOUT    = tx_sr[FRAME_W-1];
  assign spi.DAC_ALERT_N = alert_n_q;

endmodule

// File: tb/tb_ad5761r_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_ad5761r_spi_slave
// Self-checking bench for ad5761r_spi_slave: directed frames followed by
// random frames, compared against a register-level model of the DAC.
// ---------------------------------------------------------------------------
module tb_ad5761r_spi_slave;

  localparam int H       = 5;   // SCLK half period in clk cycles
  localparam int FRAME_W = 24;
`ifdef AD5761R_SLV_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dac_code;
  logic [10:0] ctrl_reg;
  logic        frame_err;

  ad5761r_spi_slave_if spi_if ();

  ad5761r_spi_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_if),
    .dac_code  (dac_code),
    .ctrl_reg  (ctrl_reg),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;

  always @(posedge clk) if (frame_err === 1'b1) err_seen <= err_seen + 1;

  // Model state: the DAC as a handful of registers.
  logic [15:0] m_in, m_dac;
  logic [10:0] m_ctrl;
  logic        m_alert;
  logic [23:0] m_rb;
  logic [23:0] m_hist;     // last 24 bits placed on DIN
  logic [23:0] rd_word;    // bits captured from DOUT
  logic [23:0] rb_exp;     // readback expected during the last frame

  function automatic logic [15:0] range_code(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16'h0000;
      2'b01:   return 16'h8000;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_in = '0; m_dac = '0; m_ctrl = '0; m_alert = 1'b0; m_rb = '0; m_hist = '0;
  endtask

  task automatic model_clear();
    if (!spi_if.DAC_CLEAR_N) m_dac = range_code(m_ctrl[10:9]);
  endtask

  task automatic model_exec();
    logic [3:0]  c;
    logic [15:0] d;
    c = m_hist[19:16];
    d = m_hist[15:0];
    case (c)
      4'h1: begin m_in = d; if (!spi_if.DAC_LOAD_N) m_dac = d; end
      4'h2: m_dac = m_in;
      4'h3: begin m_in = d; m_dac = d; end
      4'h4: begin m_ctrl = d[10:0]; m_alert = 1'b1; end
      4'h7: begin m_in = range_code(m_ctrl[4:3]); m_dac = m_in; end
      4'hA: m_rb = {8'h0A, m_in};
      4'hB: m_rb = {8'h0B, m_dac};
      4'hC: m_rb = {8'h0C, 5'h00, m_ctrl};
      4'hF: model_reset();
      default: ;
    endcase
    model_clear();
  endtask

  task automatic set_load_n(input logic v);
    if (spi_if.DAC_LOAD_N && !v) begin
      m_dac = m_in;
      model_clear();
    end
    spi_if.DAC_LOAD_N = v;
    wait_clk(4);
  endtask

  // Shift bits [first,last) of an nbits-long word, MSB first, capturing DOUT
  // just before each falling SCLK edge.
  task automatic shift_bits(input logic [23:0] w, input int nbits, input int first, input int last);
    for (int i = first; i < last; i++) begin
      spi_if.DAC_DIN = w[nbits-1-i];
      wait_clk(H);
      rd_word = {rd_word[22:0], spi_if.DAC_DOUT};
      spi_if.DAC_SCLK = 1'b0;
      m_hist = {m_hist[22:0], w[nbits-1-i]};
      wait_clk(H);
      spi_if.DAC_SCLK = 1'b1;
    end
  endtask

  // Complete frame; returns 4 clk after the CS_N rise.
  task automatic frame(input logic [23:0] w, input int nbits);
    rb_exp  = m_rb;
    m_rb    = '0;
    rd_word = '0;
    spi_if.DAC_CS_N = 1'b0;
    shift_bits(w, nbits, 0, nbits);
    wait_clk(H);
    spi_if.DAC_CS_N = 1'b1;
    wait_clk(4);
    if (FRAME_CHECK && nbits != FRAME_W) err_exp++;
    else model_exec();
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_dac"},   24'(dac_code),           24'(m_dac));
    check({tag, "_ctrl"},  24'(ctrl_reg),           24'(m_ctrl));
    check({tag, "_alert"}, 24'(spi_if.DAC_ALERT_N), 24'(m_alert));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dac"},   24'(dac_code),           24'h0);
    check({tag, "_ctrl"},  24'(ctrl_reg),           24'h0);
    check({tag, "_alert"}, 24'(spi_if.DAC_ALERT_N), 24'h0);
    check({tag, "_dout"},  24'(spi_if.DAC_DOUT),    24'h0);
    check({tag, "_ferr"},  24'(frame_err),          24'h0);
  endtask

  logic [3:0] cmd_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                               4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};

  initial begin
    logic [3:0]  rc;
    logic [15:0] rdat;
    int          pre_err;

    spi_if.DAC_SCLK    = 1'b1;
    spi_if.DAC_CS_N    = 1'b1;
    spi_if.DAC_DIN     = 1'b0;
    spi_if.DAC_RESET_N = 1'b1;
    spi_if.DAC_LOAD_N  = 1'b1;
    spi_if.DAC_CLEAR_N = 1'b1;
    model_reset();
    rd_word = '0;
    rb_exp  = '0;

    // Power-on reset
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    check_reset_state("por");

    // Write-and-update with LOAD_N low, 4 clk latency from CS_N rise
    set_load_n(1'b0);
    frame(24'h03FFFF, 24);
    check("w3_latency_dac", 24'(dac_code), 24'h00FFFF);
    set_load_n(1'b1);

    // Control write releases ALERT_N
    frame(24'h040241, 24);
    check("ctrl_write", 24'(ctrl_reg), 24'h000241);
    check("alert_rise", 24'(spi_if.DAC_ALERT_N), 24'h1);

    // DAC readback shows up on the following frame
    frame(24'h0B0000, 24);
    check("rb_none", rd_word, 24'h000000);
    frame(24'h000000, 24);
    check("rb_dac", rd_word, 24'h0BFFFF);
    frame(24'h000000, 24);
    check("rb_consumed", rd_word, 24'h000000);

    // Input write with LOAD_N high, then LDAC pulse
    frame(24'h011234, 24);
    check("w1_no_load", 24'(dac_code), 24'h00FFFF);
    set_load_n(1'b0);
    check("ldac_pulse", 24'(dac_code), 24'h001234);
    set_load_n(1'b1);

    // CLEAR_N held low overrides a cmd 3 write; input reg still updated
    spi_if.DAC_CLEAR_N = 1'b0;
    model_clear();
    wait_clk(4);
    check("clear_low", 24'(dac_code), 24'h008000);
    frame(24'h03ABCD, 24);
    check("clear_vs_w3", 24'(dac_code), 24'h008000);
    spi_if.DAC_CLEAR_N = 1'b1;
    wait_clk(4);
    check("clear_release", 24'(dac_code), 24'h008000);
    frame(24'h0A0000, 24);
    frame(24'h000000, 24);
    check("rb_input", rd_word, 24'h0AABCD);

    // Random frames against the model
    for (int k = 0; k < 16; k++) begin
      rc   = cmd_tab[$urandom_range(0, 11)];
      rdat = 16'($urandom);
      set_load_n(1'($urandom_range(0, 1)));
      frame({4'h0, rc, rdat}, 24);
      check($sformatf("rnd%0d_dout", k), rd_word, rb_exp);
      check_regs($sformatf("rnd%0d", k));
    end
    set_load_n(1'b1);

    // Software full reset
    frame(24'h040600, 24);
    frame(24'h03BEEF, 24);
    frame(24'h0F0000, 24);
    check_reset_state("cmdF");

    // Pin reset in the middle of a frame
    frame(24'h040641, 24);
    frame(24'h03C0DE, 24);
    check_regs("pre_pin_rst");
    spi_if.DAC_CS_N = 1'b0;
    shift_bits(24'h031111, 24, 0, 10);
    spi_if.DAC_RESET_N = 1'b0;
    wait_clk(4);
    check_reset_state("pin_rst");
    shift_bits(24'h031111, 24, 10, 24);
    wait_clk(H);
    spi_if.DAC_CS_N = 1'b1;
    wait_clk(4);
    spi_if.DAC_RESET_N = 1'b1;
    wait_clk(6);
    model_reset();
    check_reset_state("pin_rst_hold");
    frame(24'h035A5A, 24);
    check("post_rst_frame", 24'(dac_code), 24'h005A5A);

    // Short frame: dropped with frame_err, or last 24 bits executed
    pre_err = err_seen;
    frame(24'h031357, 20);
    wait_clk(2);
    check_regs("short_frame");
    check("short_ferr", 24'(err_seen - pre_err), FRAME_CHECK ? 24'h1 : 24'h0);
    check("ferr_total", 24'(err_seen), 24'(err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
